// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: parity encodings, receiver state encoding and the
// smallest legal baud divisor.
package uart_rx_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned BAUD_W    = 16;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam logic [BAUD_W-1:0] BAUD_MIN = BAUD_W'(7);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP1  = 3'd4,
    ST_STOP2  = 3'd5
  } state_t;

  // 2'b11 is an alias for "no parity"
  function automatic logic has_parity(input logic [1:0] sel);
    return (sel == PAR_EVEN) || (sel == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_rx_sync_edge.sv
// Multi-stage synchroniser for an asynchronous input plus a falling-edge
// detector on the synchronised level. Flops preset high (idle line level).
module uart_rx_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic n_reset,
  input  logic din,
  output logic sync,
  output logic fall_c
);

  logic [SYNC_STAGES-1:0] stages;
  logic                   sync_d;

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      stages <= '1;
      sync_d <= 1'b1;
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], din};
      sync_d <= stages[SYNC_STAGES-1];
    end
  end

  assign sync   = stages[SYNC_STAGES-1];
  assign fall_c = sync_d & ~sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, optional even/odd parity, 1 or 2 stop
// bits; configuration is captured at start detection and held for the frame.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clock,
  input  logic              n_reset,
  input  logic              rxd,
  input  logic [BAUD_W-1:0] baud_max_cnt,
  input  logic [1:0]        parity_sel,
  input  logic              stop_sel,
  output logic [7:0]        rx_data,
  output logic              rx_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  logic rxd_s;
  logic fall_c;

  uart_rx_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clock   (clock),
    .n_reset (n_reset),
    .din     (rxd),
    .sync    (rxd_s),
    .fall_c  (fall_c)
  );

  state_t                 state, state_next;
  logic [BAUD_W-1:0]      cnt;
  logic [BAUD_W-1:0]      cfg_max;
  logic [1:0]             cfg_par;
  logic                   cfg_stop;
  logic [2:0]             bit_idx;
  logic [DATA_BITS-1:0]   shift;
  logic                   par_err_int;
  logic                   frm_err_int;

  logic mid_c;
  logic start_c;
  logic finish_c;
  logic par_err_c;
  logic frm_err_c;

  // State register
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (fall_c) state_next = ST_START;
      ST_START:  if (mid_c)  state_next = rxd_s ? ST_IDLE : ST_DATA;
      ST_DATA:   if (mid_c && bit_idx == 3'd7)
                   state_next = has_parity(cfg_par) ? ST_PARITY : ST_STOP1;
      ST_PARITY: if (mid_c)  state_next = ST_STOP1;
      ST_STOP1:  if (mid_c)  state_next = cfg_stop ? ST_STOP2 : ST_IDLE;
      ST_STOP2:  if (mid_c)  state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Decode of sample strobes and the values committed at each sample
  always_comb begin
    mid_c     = (cnt == (cfg_max >> 1));
    start_c   = (state == ST_IDLE) && fall_c;
    finish_c  = mid_c && (((state == ST_STOP1) && !cfg_stop) || (state == ST_STOP2));
    par_err_c = (^shift) ^ rxd_s ^ (cfg_par == PAR_ODD);
    frm_err_c = ~rxd_s;
    if (state == ST_STOP2) frm_err_c = frm_err_int | ~rxd_s;
  end

  // Frame datapath: baud counter, config latch, shift register, error flags
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      cnt         <= '0;
      cfg_max     <= BAUD_MIN;
      cfg_par     <= PAR_NONE;
      cfg_stop    <= 1'b0;
      bit_idx     <= '0;
      shift       <= '0;
      par_err_int <= 1'b0;
      frm_err_int <= 1'b0;
    end else begin
      if (state == ST_IDLE || cnt == cfg_max) cnt <= '0;
      else                                     cnt <= cnt + BAUD_W'(1);

      if (start_c) begin
        cfg_max     <= (baud_max_cnt < BAUD_MIN) ? BAUD_MIN : baud_max_cnt;
        cfg_par     <= parity_sel;
        cfg_stop    <= stop_sel;
        bit_idx     <= '0;
        par_err_int <= 1'b0;
        frm_err_int <= 1'b0;
      end

      if (mid_c) begin
        case (state)
          ST_DATA: begin
            shift   <= {rxd_s, shift[DATA_BITS-1:1]};
            bit_idx <= bit_idx + 3'd1;
          end
          ST_PARITY:          par_err_int <= par_err_c;
          ST_STOP1, ST_STOP2: frm_err_int <= frm_err_c;
          default: ;
        endcase
      end
    end
  end

  // Registered outputs; flags and data only change on a strobe
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      rx_valid <= finish_c;
      busy     <= (state_next != ST_IDLE);
      if (finish_c) begin
        rx_data    <= shift;
        parity_err <= par_err_int;
        frame_err  <= frm_err_c;
      end
    end
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver that consumes the uart_txd line produced by the button-driven transmit path, closing the loopback.
- Recovers 8-bit characters framed as start, 8 data bits (LSB first), optional parity, then 1 or 2 stop bits.
- Bit timing, parity and stop configuration use the same encoding as uart_tx, so both ends share one configuration.
- Outputs are a one-cycle data strobe plus error flags, consumed by a display or compare stage.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the rxd metastability synchroniser (minimum 2).

Ports:
- clock  input  1  system clock (100 MHz nominal)
- n_reset  input  1  reset, asynchronous, active-low
- rxd  input  1  asynchronous serial line; idles high
- baud_max_cnt  input  16  bit period in clocks minus 1 (10416 gives 9600 baud at 100 MHz); minimum legal value 7
- parity_sel  input  2  00 none, 01 even, 10 odd, 11 none
- stop_sel  input  1  0 = one stop bit, 1 = two stop bits
- rx_data  output  8  last received character
- rx_valid  output  1  one-cycle strobe; rx_data, parity_err and frame_err are valid in this cycle
- parity_err  output  1  parity mismatch on the frame being strobed
- frame_err  output  1  a stop bit was sampled low on the frame being strobed
- busy  output  1  high from start-edge detection until return to IDLE

Behaviour:
- Reset (asynchronous, any state, including mid-frame):
  - rx_data=0, rx_valid=0, parity_err=0, frame_err=0, busy=0.
  - Synchroniser flops preset to 1; state = IDLE; counters = 0.
  - No partial frame is ever reported.
- Synchroniser:
  - rxd passes through SYNC_STAGES flops to give rxd_s.
  - One extra flop holds rxd_d for falling-edge detection.
- Configuration latch:
  - baud_max_cnt, parity_sel and stop_sel are latched at start detection.
  - Changes to these inputs mid-frame have no effect until the next frame.
- Baud counter:
  - Counts 0..cfg_max, then wraps to 0.
  - Mid-bit sample point is count == cfg_max>>1.
- State machine: IDLE, START, DATA, PARITY, STOP1, STOP2.
  - IDLE: on rxd_d=1 and rxd_s=0, go to START, clear the counter, set busy.
  - START: at mid-bit, if rxd_s=1 it is a false start (glitch): return to IDLE with no strobe and no error. If rxd_s=0, realign so later samples fall mid-bit, then go to DATA.
  - DATA: sample once per bit period at mid-bit. Shift into a shift register, LSB first. A bit index (0..7) counts the bits. After bit 7, go to PARITY if parity_sel is 01 or 10, else STOP1.
  - PARITY: sample one bit. Even parity: error if XOR of data^parity = 1. Odd parity: error if it = 0. Go to STOP1.
  - STOP1: sample the stop bit; frame_err_int = ~rxd_s. If stop_sel=0, finish. If stop_sel=1, go to STOP2.
  - STOP2: sample; frame_err_int |= ~rxd_s; finish.
- Finish:
  - The cycle after the final stop sample, set rx_valid=1 for exactly one cycle.
  - In that cycle, rx_data = shift register, and parity_err and frame_err are updated.
  - rx_data holds until the next strobe. The error flags also hold until the next strobe.
  - State returns to IDLE and busy=0 in the same cycle.
- Re-arm and break handling:
  - Re-arm requires a new falling edge.
  - After a frame_err with the line still low (break), no new start is detected until rxd_s has been 1 for at least one cycle.
- Latency: rx_valid rises 1 clock after the mid-sample of the last stop bit, plus SYNC_STAGES clocks of input delay.
- Back-to-back frames (start edge immediately after the stop bit) must be received without loss.

Decomposition:
- Shared package holds:
  - Parity encodings PAR_NONE=2'b00, PAR_EVEN=2'b01, PAR_ODD=2'b10.
  - The state encoding.
  - The minimum legal baud_max_cnt value.
  uart_tx and uart_rx use the same package.
- One sub-module is natural: sync_edge (parameterised synchroniser plus falling-edge detector), reusable for other asynchronous inputs.

Test Plan:
- Default configuration (baud_max_cnt=15, parity 00, stop 0), drive frame 0x41 -> one rx_valid pulse, rx_data=0x41, both errors 0, busy low afterwards.
- uart_tx looped to uart_rx with identical configuration. Send 0x41, 0x42, 0x43, 0x44 back-to-back -> four strobes with matching data, no errors.
- Even parity, send 0x43 with the parity bit inverted -> rx_data=0x43, parity_err=1, frame_err=0. Repeat in odd mode with correct parity -> parity_err=0.
- stop_sel=1, second stop bit driven low -> frame_err=1. Hold line low 3 frame times -> exactly one strobe, no further strobes until the line returns high.
- Low glitch shorter than half a bit period in IDLE -> no rx_valid, busy returns to 0, next valid frame 0x44 received correctly.
- Assert n_reset during DATA bit 4 -> all outputs 0 immediately, no strobe. After release, next frame 0x42 received correctly.
